// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary register.
// Captures register-file read data (with same-cycle WB bypass) and decoded ID
// fields into EX-stage registers. Detects load-use hazards against the load
// currently in EX and requests an upstream stall, inserting one bubble.
// Keeps a saturating count of stall cycles.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [4:0]        id_rn,
  input  logic [4:0]        id_rm,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rm,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rn,
  output logic [4:0]        ex_rm,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  stall_count
);

  // Register 31 reads as zero and is never a real bypass/hazard source.
  localparam logic [4:0]       XZR     = 5'd31;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              bypass_a;
  logic              bypass_b;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic              rn_hit;
  logic              rm_hit;
  logic              load_use;
  logic              bubble;

  // Operand selection: XZR first, then WB bypass, else register-file data.
  always_comb begin
    bypass_a = wb_reg_write && (wb_rd == id_rn) && (id_rn != XZR);
    bypass_b = wb_reg_write && (wb_rd == id_rm) && (id_rm != XZR);
    opnd_a   = id_rdata1;
    opnd_b   = id_rdata2;
    if (id_rn == XZR)
      opnd_a = '0;
    else if (bypass_a)
      opnd_a = wb_data;
    if (id_rm == XZR)
      opnd_b = '0;
    else if (bypass_b)
      opnd_b = wb_data;
  end

  // Load-use detection uses only registered EX state plus current ID/flush.
  // A flush squashes the ID instruction, so it cancels the stall request.
  always_comb begin
    rn_hit   = (ex_rd == id_rn);
    rm_hit   = id_uses_rm && (ex_rd == id_rm);
    load_use = ex_valid && ex_mem_read && (ex_rd != XZR) && id_valid &&
               (rn_hit || rm_hit) && !flush;
    stall    = load_use && !reset;
    bubble   = flush || load_use;
  end

  // EX-stage capture: reset clears, flush/stall insert a fully-zeroed bubble,
  // otherwise capture ID with control forced off for an invalid ID slot.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      ex_rn        <= '0;
      ex_rm        <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_a         <= opnd_a;
      ex_b         <= opnd_b;
      ex_imm       <= id_imm;
      ex_rn        <= id_rn;
      ex_rm        <= id_rm;
      ex_rd        <= id_rd;
      ex_ctrl      <= id_valid ? id_ctrl : '0;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_reg_write <= id_valid && id_reg_write;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (stall && (stall_count != CNT_MAX))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass, XZR, bubbles, load-use stall,
// flush override, counter saturation (1-bit counter instance) and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_uses_rm;
  logic [63:0] id_rdata1, id_rdata2, id_imm;
  logic [15:0] id_ctrl;
  logic        id_mem_read, id_reg_write;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;

  logic        stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [63:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic [15:0] ex_ctrl;
  logic [31:0] stall_count;

  logic        s_stall, s_ex_valid, s_ex_mem_read, s_ex_reg_write;
  logic [63:0] s_ex_pc, s_ex_a, s_ex_b, s_ex_imm;
  logic [4:0]  s_ex_rn, s_ex_rm, s_ex_rd;
  logic [15:0] s_ex_ctrl;
  logic [0:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(64), .CTRL_W(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_uses_rm(id_uses_rm),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rn(ex_rn), .ex_rm(ex_rm),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .stall_count(stall_count)
  );

  id_ex_stage #(.DATA_W(64), .CTRL_W(16), .CNT_W(1)) dut_c1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_uses_rm(id_uses_rm),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
    .ex_a(s_ex_a), .ex_b(s_ex_b), .ex_imm(s_ex_imm), .ex_rn(s_ex_rn),
    .ex_rm(s_ex_rm), .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl),
    .ex_mem_read(s_ex_mem_read), .ex_reg_write(s_ex_reg_write),
    .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiet, valid ALU instruction in ID with no WB activity.
  task automatic id_alu(input logic [63:0] pc, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [4:0] rd);
    id_valid = 1'b1; id_pc = pc; id_rn = rn; id_rm = rm; id_rd = rd;
    id_uses_rm = 1'b1; id_rdata1 = 64'h1111; id_rdata2 = 64'h2222;
    id_imm = 64'h7; id_ctrl = 16'h00A5; id_mem_read = 1'b0;
    id_reg_write = 1'b1; wb_reg_write = 1'b0; wb_rd = 5'd0;
    wb_data = 64'h0; flush = 1'b0;
  endtask

  task automatic load_x5_into_ex(input logic [63:0] pc);
    id_alu(pc, 5'd1, 5'd2, 5'd5);
    id_mem_read = 1'b1;
    tick();
  endtask

  initial begin
    // Reset held with random inputs.
    reset = 1'b1;
    id_valid = 1'($urandom); id_pc = {$urandom, $urandom};
    id_rn = 5'($urandom); id_rm = 5'($urandom); id_rd = 5'($urandom);
    id_uses_rm = 1'($urandom); id_rdata1 = {$urandom, $urandom};
    id_rdata2 = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
    id_ctrl = 16'($urandom); id_mem_read = 1'($urandom);
    id_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
    wb_rd = 5'($urandom); wb_data = {$urandom, $urandom}; flush = 1'($urandom);
    tick();
    tick();
    chk("rst_valid", 64'(ex_valid), 64'h0);
    chk("rst_pc", ex_pc, 64'h0);
    chk("rst_a", ex_a, 64'h0);
    chk("rst_b", ex_b, 64'h0);
    chk("rst_imm", ex_imm, 64'h0);
    chk("rst_idx", {49'h0, ex_rn, ex_rm, ex_rd}, 64'h0);
    chk("rst_ctrl", 64'(ex_ctrl), 64'h0);
    chk("rst_flags", {62'h0, ex_mem_read, ex_reg_write}, 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_count", 64'(stall_count), 64'h0);
    chk("rst_count1", 64'(s_stall_count), 64'h0);
    reset = 1'b0;

    // Bypass on rn, rm from regfile.
    id_alu(64'h100, 5'd3, 5'd4, 5'd9);
    id_rdata1 = 64'h11; id_rdata2 = 64'h22;
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 64'hAB;
    tick();
    chk("byp_a", ex_a, 64'hAB);
    chk("byp_b_rf", ex_b, 64'h22);
    chk("byp_valid", 64'(ex_valid), 64'h1);
    chk("byp_pc", ex_pc, 64'h100);
    chk("byp_ctrl", 64'(ex_ctrl), 64'h00A5);
    chk("byp_rd", 64'(ex_rd), 64'd9);

    // XZR: matching WB write to x31 must not bypass; operand is zero.
    id_alu(64'h104, 5'd31, 5'd31, 5'd9);
    id_rdata1 = 64'h55; id_rdata2 = 64'h66;
    wb_reg_write = 1'b1; wb_rd = 5'd31; wb_data = 64'hAB;
    tick();
    chk("xzr_a", ex_a, 64'h0);
    chk("xzr_b", ex_b, 64'h0);

    // Bypass on rm; WB disabled leaves rn on regfile data.
    id_alu(64'h108, 5'd7, 5'd8, 5'd9);
    id_rdata1 = 64'h77; id_rdata2 = 64'h88;
    wb_reg_write = 1'b1; wb_rd = 5'd8; wb_data = 64'hCD;
    tick();
    chk("byp_rm_b", ex_b, 64'hCD);
    chk("byp_rm_a", ex_a, 64'h77);
    wb_reg_write = 1'b0; wb_rd = 5'd7;
    tick();
    chk("nowb_a", ex_a, 64'h77);

    // Invalid ID slot: control/flags forced off, data captured.
    id_alu(64'h10C, 5'd1, 5'd2, 5'd3);
    id_valid = 1'b0; id_ctrl = 16'hFFFF; id_mem_read = 1'b1;
    tick();
    chk("inv_valid", 64'(ex_valid), 64'h0);
    chk("inv_ctrl", 64'(ex_ctrl), 64'h0);
    chk("inv_flags", {62'h0, ex_mem_read, ex_reg_write}, 64'h0);
    chk("inv_pc", ex_pc, 64'h10C);

    // Load-use on rn: one stall, one bubble, then capture.
    load_x5_into_ex(64'h200);
    chk("ld_memrd", 64'(ex_mem_read), 64'h1);
    id_alu(64'h204, 5'd5, 5'd2, 5'd6);
    #1;
    chk("lu_stall", 64'(stall), 64'h1);
    tick();
    chk("lu_bub_valid", 64'(ex_valid), 64'h0);
    chk("lu_bub_pc", ex_pc, 64'h0);
    chk("lu_bub_ctrl", 64'(ex_ctrl), 64'h0);
    chk("lu_stall_drop", 64'(stall), 64'h0);
    chk("lu_count", 64'(stall_count), 64'h1);
    chk("lu_count1", 64'(s_stall_count), 64'h1);
    tick();
    chk("lu_cap_valid", 64'(ex_valid), 64'h1);
    chk("lu_cap_pc", ex_pc, 64'h204);
    chk("lu_cap_rd", 64'(ex_rd), 64'd6);
    chk("lu_count_hold", 64'(stall_count), 64'h1);

    // rm match only counts when the instruction uses rm.
    load_x5_into_ex(64'h300);
    id_alu(64'h304, 5'd1, 5'd5, 5'd6);
    #1;
    chk("rm_used_stall", 64'(stall), 64'h1);
    id_uses_rm = 1'b0;
    #1;
    chk("rm_unused_stall", 64'(stall), 64'h0);
    tick();
    chk("rm_unused_cap", ex_pc, 64'h304);

    // Flush overrides a load-use hazard.
    load_x5_into_ex(64'h400);
    id_alu(64'h404, 5'd5, 5'd2, 5'd6);
    flush = 1'b1;
    #1;
    chk("fl_stall", 64'(stall), 64'h0);
    tick();
    chk("fl_valid", 64'(ex_valid), 64'h0);
    chk("fl_pc", ex_pc, 64'h0);
    chk("fl_count", 64'(stall_count), 64'h1);

    // Second stall cycle: wide counter to 2, 1-bit counter saturates at 1.
    load_x5_into_ex(64'h500);
    id_alu(64'h504, 5'd5, 5'd2, 5'd6);
    tick();
    chk("sat_count", 64'(stall_count), 64'h2);
    chk("sat_count1", 64'(s_stall_count), 64'h1);

    // Reset during a stall.
    load_x5_into_ex(64'h600);
    id_alu(64'h604, 5'd5, 5'd2, 5'd6);
    #1;
    chk("mid_stall", 64'(stall), 64'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", 64'(stall), 64'h0);
    tick();
    chk("mid_rst_valid", 64'(ex_valid), 64'h0);
    chk("mid_rst_pc", ex_pc, 64'h0);
    chk("mid_rst_a", ex_a, 64'h0);
    chk("mid_rst_flags", {62'h0, ex_mem_read, ex_reg_write}, 64'h0);
    chk("mid_rst_count", 64'(stall_count), 64'h0);
    chk("mid_rst_count1", 64'(s_stall_count), 64'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_stall", 64'(stall), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
